game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
- Top-level game sequencer. Consumes per-pixel collision flags from the collision detector and turns them into game state.
- Tracks lives, level and invulnerability, and sequences play / death / respawn / level-complete / game-over phases.
- Drives player_invulnerable back into the collision detector. Drives freeze and restart controls to the player, enemy and bomb blocks.
- All timing is counted in frames using startOfFrame; the block itself runs at clk rate.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..7)
- MAX_LEVEL, 3, last level index; completing it gives WIN
- DEATH_FRAMES, 60, frames spent in DEATH before respawn or game over
- RESPAWN_INVULN_FRAMES, 90, invulnerability after respawn
- POWERUP_INVULN_FRAMES, 150, invulnerability granted by a power-up
- LEVEL_DONE_FRAMES, 60, frames of level-complete pause
- TIMER_W, 8, width of frame timers; all *_FRAMES values must be < 2^TIMER_W

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- start_key  in  1  level-sensitive start button
- player_hit  in  1  player/blast or player/enemy overlap, pixel-rate
- player_door_idol  in  1  player on exposed door, pixel-rate
- collision_player_powerUp  in  1  player on power-up, pixel-rate
- enemies_cleared  in  1  high when all enemies of the level are dead
- player_invulnerable  out  1  blocks further hits
- lives  out  3  remaining lives
- level  out  2  current level, 0-based
- freeze  out  1  halts player, enemy and bomb motion
- level_restart  out  1  one-cycle pulse: reload map and positions for `level`
- powerup_taken  out  1  one-cycle pulse: power-up consumed
- game_over  out  1  high in GAME_OVER
- game_won  out  1  high in WIN

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, lives=LIVES_INIT, level=0, player_invulnerable=0, freeze=1, game_over=0, game_won=0, all pulses=0, timers=0.
- Reset takes priority over every event, including reset arriving mid-DEATH or mid-timer.
- IDLE: freeze=1. On start_key=1: level=0, lives=LIVES_INIT, pulse level_restart, go to PLAY on the next cycle.
- PLAY: freeze=0.
  - Event priority within a cycle: hit > door > power-up.
  - Hit is accepted only if player_hit=1 and invuln_timer=0.
  - Door is accepted only if player_door_idol=1 and enemies_cleared=1.
  - Hit: lives -= 1, death_timer=DEATH_FRAMES, go to DEATH.
  - Door: level_timer=LEVEL_DONE_FRAMES, go to LEVEL_DONE.
  - Power-up: invuln_timer = max(invuln_timer, POWERUP_INVULN_FRAMES), pulse powerup_taken once.
  - Power-up re-arms only after collision_player_powerUp has been low for one full frame, so a multi-pixel overlap yields one pulse.
- DEATH: freeze=1. death_timer decrements on each startOfFrame. At 0:
  - lives=0: go to GAME_OVER.
  - otherwise: pulse level_restart, invuln_timer=RESPAWN_INVULN_FRAMES, go to PLAY.
- LEVEL_DONE: freeze=1. level_timer decrements on each startOfFrame. At 0:
  - level=MAX_LEVEL: go to WIN.
  - otherwise: level += 1, pulse level_restart, invuln_timer=0, go to PLAY.
- GAME_OVER and WIN: freeze=1, game_over or game_won held high.
  - start_key must be seen low then high (rising edge, sampled per clk). On that edge, return to IDLE start behaviour: level=0, lives=LIVES_INIT, level_restart pulse, then PLAY.
- invuln_timer:
  - Decrements on startOfFrame in PLAY only. Saturates at 0. Holds its value in other states.
  - player_invulnerable = (invuln_timer != 0) in PLAY; forced 1 in DEATH and LEVEL_DONE.
- Timer loaded in the same cycle as a startOfFrame: the load wins and there is no decrement that cycle.
- Latency:
  - Hit/door/power-up to state or output change: 1 clk.
  - Timer expiry to next state: 1 clk after the startOfFrame that reaches 0.
- lives never underflows: a hit is only possible with lives>=1. level never exceeds MAX_LEVEL.
- player_hit is asserted on many pixels per frame. After the first accepted hit the FSM is in DEATH, so no double decrement occurs.

Test Plan:
- Reset, start_key=1 for 1 clk -> level_restart pulse, state PLAY, lives=3, level=0, freeze=0 within 2 clks.
- In PLAY, player_hit high for 40 consecutive clks -> lives 3->2 exactly once; freeze=1 for 60 frames; then level_restart pulse and player_invulnerable=1 for 90 frames; a hit during those frames leaves lives=2.
- Three accepted hits (each after invulnerability expires) -> after the third DEATH, game_over=1 and lives=0. start_key held high through the transition gives no restart; release then press -> lives=3, level=0.
- player_door_idol=1 with enemies_cleared=0 -> no change. With enemies_cleared=1 at level 0 -> LEVEL_DONE for 60 frames, then level=1 and level_restart pulse. Repeat at level 3 -> game_won=1.
- Power-up overlap for 20 clks with invuln_timer=30 -> one powerup_taken pulse, invuln_timer=150. Same-cycle player_hit + player_door_idol (invuln 0, cleared) -> DEATH taken, level unchanged.
- reset asserted mid-DEATH with death_timer=25 -> next clk: IDLE, lives=3, level=0, freeze=1, all pulses 0.

Source files
------------

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - play/death/respawn/level/game-over sequencer
`timescale 1ns/1ps
module game_flow_controller #(
  parameter int LIVES_INIT            = 3,
  parameter int MAX_LEVEL             = 3,
  parameter int DEATH_FRAMES          = 60,
  parameter int RESPAWN_INVULN_FRAMES = 90,
  parameter int POWERUP_INVULN_FRAMES = 150,
  parameter int LEVEL_DONE_FRAMES     = 60,
  parameter int TIMER_W               = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       start_key,
  input  logic       player_hit,
  input  logic       player_door_idol,
  input  logic       collision_player_powerUp,
  input  logic       enemies_cleared,
  output logic       player_invulnerable,
  output logic [2:0] lives,
  output logic [1:0] level,
  output logic       freeze,
  output logic       level_restart,
  output logic       powerup_taken,
  output logic       game_over,
  output logic       game_won
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_DEATH,
    S_LEVEL_DONE,
    S_GAME_OVER,
    S_WIN
  } state_t;

  localparam logic [TIMER_W-1:0] DEATH_T   = TIMER_W'(DEATH_FRAMES);
  localparam logic [TIMER_W-1:0] RESPAWN_T = TIMER_W'(RESPAWN_INVULN_FRAMES);
  localparam logic [TIMER_W-1:0] POWERUP_T = TIMER_W'(POWERUP_INVULN_FRAMES);
  localparam logic [TIMER_W-1:0] LEVEL_T   = TIMER_W'(LEVEL_DONE_FRAMES);
  localparam logic [TIMER_W-1:0] ONE_T     = TIMER_W'(1);
  localparam logic [2:0]         LIVES_T   = 3'(LIVES_INIT);
  localparam logic [1:0]         MAX_LVL_T = 2'(MAX_LEVEL);

  state_t             state, state_n;
  logic [TIMER_W-1:0] invuln_timer, invuln_n;
  logic [TIMER_W-1:0] death_timer, death_n;
  logic [TIMER_W-1:0] level_timer, level_timer_n;
  logic [2:0]         lives_n;
  logic [1:0]         level_n;
  logic               restart_n, pu_taken_n;
  // pu_armed: a power-up may be taken; pu_quiet: a frame boundary has passed
  // since the last take; pu_seen: overlap seen since the last frame boundary.
  logic               pu_armed, pu_armed_n;
  logic               pu_quiet, pu_quiet_n;
  logic               pu_seen, pu_seen_n;
  logic               start_key_q;
  logic               hit_ok, door_ok, pu_ok, key_rise, begin_game;

  // Next-state, timer and event decode for the game sequencer
  always_comb begin
    hit_ok        = player_hit && (invuln_timer == '0);
    door_ok       = player_door_idol && enemies_cleared;
    pu_ok         = collision_player_powerUp && pu_armed;
    key_rise      = start_key && !start_key_q;
    begin_game    = 1'b0;
    state_n       = state;
    lives_n       = lives;
    level_n       = level;
    invuln_n      = invuln_timer;
    death_n       = death_timer;
    level_timer_n = level_timer;
    restart_n     = 1'b0;
    pu_taken_n    = 1'b0;
    pu_seen_n     = startOfFrame ? collision_player_powerUp : (pu_seen | collision_player_powerUp);
    pu_armed_n    = pu_armed;
    pu_quiet_n    = pu_quiet;

    if (startOfFrame && !pu_armed) begin
      if (pu_quiet && !pu_seen) pu_armed_n = 1'b1;
      pu_quiet_n = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start_key) begin_game = 1'b1;
      end
      S_PLAY: begin
        if (hit_ok) begin
          lives_n = lives - 3'd1;
          death_n = DEATH_T;
          state_n = S_DEATH;
        end else begin
          if (door_ok) begin
            level_timer_n = LEVEL_T;
            state_n       = S_LEVEL_DONE;
          end
          if (!door_ok && pu_ok) begin
            invuln_n   = (invuln_timer > POWERUP_T) ? invuln_timer : POWERUP_T;
            pu_taken_n = 1'b1;
            pu_armed_n = 1'b0;
            pu_quiet_n = 1'b0;
          end else if (startOfFrame && (invuln_timer != '0)) begin
            invuln_n = invuln_timer - ONE_T;
          end
        end
      end
      S_DEATH: begin
        if (death_timer == '0) begin
          if (lives == 3'd0) begin
            state_n = S_GAME_OVER;
          end else begin
            restart_n = 1'b1;
            invuln_n  = RESPAWN_T;
            state_n   = S_PLAY;
          end
        end else if (startOfFrame) begin
          death_n = death_timer - ONE_T;
        end
      end
      S_LEVEL_DONE: begin
        if (level_timer == '0) begin
          if (level == MAX_LVL_T) begin
            state_n = S_WIN;
          end else begin
            level_n   = level + 2'd1;
            restart_n = 1'b1;
            invuln_n  = '0;
            state_n   = S_PLAY;
          end
        end else if (startOfFrame) begin
          level_timer_n = level_timer - ONE_T;
        end
      end
      S_GAME_OVER, S_WIN: begin
        if (key_rise) begin_game = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (begin_game) begin
      state_n   = S_PLAY;
      lives_n   = LIVES_T;
      level_n   = '0;
      invuln_n  = '0;
      restart_n = 1'b1;
    end
  end

  // State, counters and power-up re-arm tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      lives        <= LIVES_T;
      level        <= '0;
      invuln_timer <= '0;
      death_timer  <= '0;
      level_timer  <= '0;
      pu_armed     <= 1'b1;
      pu_quiet     <= 1'b1;
      pu_seen      <= 1'b0;
      start_key_q  <= 1'b0;
    end else begin
      state        <= state_n;
      lives        <= lives_n;
      level        <= level_n;
      invuln_timer <= invuln_n;
      death_timer  <= death_n;
      level_timer  <= level_timer_n;
      pu_armed     <= pu_armed_n;
      pu_quiet     <= pu_quiet_n;
      pu_seen      <= pu_seen_n;
      start_key_q  <= start_key;
    end
  end

  // Registered control outputs, decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      player_invulnerable <= 1'b0;
      freeze              <= 1'b1;
      level_restart       <= 1'b0;
      powerup_taken       <= 1'b0;
      game_over           <= 1'b0;
      game_won            <= 1'b0;
    end else begin
      player_invulnerable <= (state_n == S_PLAY) ? (invuln_n != '0)
                           : ((state_n == S_DEATH) || (state_n == S_LEVEL_DONE));
      freeze              <= (state_n != S_PLAY);
      level_restart       <= restart_n;
      powerup_taken       <= pu_taken_n;
      game_over           <= (state_n == S_GAME_OVER);
      game_won            <= (state_n == S_WIN);
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - scenario and randomized bench for game_flow_controller
`timescale 1ns/1ps
module tb_game_flow_controller;
  localparam int LIVES_INIT = 3;
  localparam int MAX_LEVEL  = 3;
  localparam int DEATH_F    = 60;
  localparam int RESPAWN_F  = 90;
  localparam int POWERUP_F  = 150;
  localparam int LEVEL_F    = 60;
  localparam int FRAME_CLKS = 4;
  localparam int P_IDLE = 0, P_PLAY = 1, P_DEATH = 2, P_LEVEL = 3, P_OVER = 4, P_WIN = 5;

  logic clk = 1'b0;
  logic reset, startOfFrame, start_key, player_hit, player_door_idol;
  logic collision_player_powerUp, enemies_cleared;
  logic player_invulnerable, freeze, level_restart, powerup_taken, game_over, game_won;
  logic [2:0] lives;
  logic [1:0] level;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural game model
  int m_phase, m_lives, m_level, m_inv, m_death, m_ltimer, m_fidx, m_pulse_frame;
  bit m_restart, m_pu, m_key_prev, m_armed, m_frame_high;
  bit sof_random, sof_at_edge;
  int frame_cnt;

  game_flow_controller dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_key(start_key),
    .player_hit(player_hit), .player_door_idol(player_door_idol),
    .collision_player_powerUp(collision_player_powerUp), .enemies_cleared(enemies_cleared),
    .player_invulnerable(player_invulnerable), .lives(lives), .level(level), .freeze(freeze),
    .level_restart(level_restart), .powerup_taken(powerup_taken),
    .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = P_IDLE; m_lives = LIVES_INIT; m_level = 0; m_inv = 0; m_death = 0; m_ltimer = 0;
    m_restart = 0; m_pu = 0; m_key_prev = 0; m_armed = 1; m_frame_high = 0;
    m_fidx = 0; m_pulse_frame = -1;
  endtask

  task automatic model_step();
    bit rise, armed_before, start_game;
    if (reset) begin
      model_reset();
      return;
    end
    rise = start_key && !m_key_prev;
    m_key_prev = start_key;
    armed_before = m_armed;
    start_game = 0;
    m_restart = 0;
    m_pu = 0;
    // a power-up re-arms once a whole frame (SOF to SOF) after the take had no overlap
    if (startOfFrame) begin
      if (!m_armed && m_fidx > m_pulse_frame && !m_frame_high) m_armed = 1;
      m_fidx++;
      m_frame_high = collision_player_powerUp;
    end else begin
      m_frame_high = m_frame_high | collision_player_powerUp;
    end
    case (m_phase)
      P_IDLE: if (start_key) start_game = 1;
      P_PLAY: begin
        if (player_hit && m_inv == 0) begin
          m_lives = m_lives - 1; m_death = DEATH_F; m_phase = P_DEATH;
        end else if (player_door_idol && enemies_cleared) begin
          m_ltimer = LEVEL_F; m_phase = P_LEVEL;
          if (startOfFrame && m_inv > 0) m_inv = m_inv - 1;
        end else if (collision_player_powerUp && armed_before) begin
          m_inv = (m_inv > POWERUP_F) ? m_inv : POWERUP_F;
          m_pu = 1; m_armed = 0; m_pulse_frame = m_fidx;
        end else if (startOfFrame && m_inv > 0) begin
          m_inv = m_inv - 1;
        end
      end
      P_DEATH: begin
        if (m_death == 0) begin
          if (m_lives == 0) m_phase = P_OVER;
          else begin m_restart = 1; m_inv = RESPAWN_F; m_phase = P_PLAY; end
        end else if (startOfFrame) m_death = m_death - 1;
      end
      P_LEVEL: begin
        if (m_ltimer == 0) begin
          if (m_level == MAX_LEVEL) m_phase = P_WIN;
          else begin m_level = m_level + 1; m_restart = 1; m_inv = 0; m_phase = P_PLAY; end
        end else if (startOfFrame) m_ltimer = m_ltimer - 1;
      end
      default: if (rise) start_game = 1;
    endcase
    if (start_game) begin
      m_phase = P_PLAY; m_lives = LIVES_INIT; m_level = 0; m_inv = 0; m_restart = 1;
    end
  endtask

  // one clock: model consumes the inputs seen at the edge, then the frame strobe advances
  task automatic cyc();
    @(posedge clk);
    #1;
    sof_at_edge = startOfFrame;
    model_step();
    frame_cnt++;
    if (sof_random) startOfFrame = ($urandom_range(0, 3) == 0);
    else            startOfFrame = ((frame_cnt % FRAME_CLKS) == 0);
  endtask

  task automatic wait_restart(output bit ok, output int sofs);
    ok = 0; sofs = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (level_restart) begin ok = 1; break; end
      sofs += int'(sof_at_edge);
    end
  endtask

  task automatic wait_invuln_clear(output bit ok, output int sofs);
    ok = 0; sofs = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      sofs += int'(sof_at_edge);
      if (!player_invulnerable) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1; cyc(); cyc();
    n_cmp++;
    if ({freeze, player_invulnerable, level_restart, powerup_taken, game_over, game_won} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 100000",
        {freeze, player_invulnerable, level_restart, powerup_taken, game_over, game_won});
    end
    n_cmp++;
    if (lives !== 3'd3 || level !== 2'd0) begin
      n_bad++; $display("FAIL reset_counts: got lives %0d level %0d expected 3 0", lives, level);
    end
    reset = 0;
  endtask

  task automatic test_start();
    start_key = 1; cyc(); start_key = 0;
    n_cmp++;
    if (level_restart !== 1'b1 || freeze !== 1'b0 || lives !== 3'd3 || level !== 2'd0) begin
      n_bad++; $display("FAIL start: got restart %b freeze %b lives %0d level %0d expected 1 0 3 0",
        level_restart, freeze, lives, level);
    end
    cyc();
    n_cmp++;
    if (level_restart !== 1'b0 || freeze !== 1'b0) begin
      n_bad++; $display("FAIL start_pulse_width: got restart %b freeze %b expected 0 0", level_restart, freeze);
    end
  endtask

  task automatic test_hit_death();
    bit ok; int sofs;
    player_hit = 1; cyc();
    n_cmp++;
    if (lives !== 3'd2 || freeze !== 1'b1 || player_invulnerable !== 1'b1) begin
      n_bad++; $display("FAIL hit_enter_death: got lives %0d freeze %b inv %b expected 2 1 1", lives, freeze, player_invulnerable);
    end
    ok = 0; sofs = 0;
    for (int i = 0; i < 3000; i++) begin
      player_hit = (i < 39);
      cyc();
      if (level_restart) begin ok = 1; break; end
      sofs += int'(sof_at_edge);
    end
    player_hit = 0;
    n_cmp++;
    if (!ok || sofs != DEATH_F || lives !== 3'd2 || freeze !== 1'b0 || player_invulnerable !== 1'b1) begin
      n_bad++; $display("FAIL death_respawn: got ok %0d frames %0d lives %0d freeze %b inv %b expected 1 %0d 2 0 1",
        ok, sofs, lives, freeze, player_invulnerable, DEATH_F);
    end
    ok = 0; sofs = 0;
    for (int i = 0; i < 3000; i++) begin
      player_hit = (i >= 10 && i < 30);
      cyc();
      sofs += int'(sof_at_edge);
      if (!player_invulnerable) begin ok = 1; break; end
    end
    player_hit = 0;
    n_cmp++;
    if (!ok || sofs != RESPAWN_F || lives !== 3'd2) begin
      n_bad++; $display("FAIL respawn_invuln: got ok %0d frames %0d lives %0d expected 1 %0d 2", ok, sofs, lives, RESPAWN_F);
    end
  endtask

  task automatic test_game_over();
    bit ok; int sofs;
    player_hit = 1; cyc(); player_hit = 0;
    wait_restart(ok, sofs);
    wait_invuln_clear(ok, sofs);
    n_cmp++;
    if (!ok || lives !== 3'd1) begin
      n_bad++; $display("FAIL second_life: got ok %0d lives %0d expected 1 1", ok, lives);
    end
    player_hit = 1; start_key = 1; cyc(); player_hit = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (game_over) begin ok = 1; break; end
    end
    repeat (5) cyc();
    n_cmp++;
    if (!ok || game_over !== 1'b1 || lives !== 3'd0 || freeze !== 1'b1 || level_restart !== 1'b0) begin
      n_bad++; $display("FAIL game_over_hold: got ok %0d over %b lives %0d freeze %b restart %b expected 1 1 0 1 0",
        ok, game_over, lives, freeze, level_restart);
    end
    start_key = 0; cyc(); start_key = 1; cyc(); start_key = 0;
    n_cmp++;
    if (level_restart !== 1'b1 || lives !== 3'd3 || level !== 2'd0 || game_over !== 1'b0 || freeze !== 1'b0) begin
      n_bad++; $display("FAIL game_over_restart: got restart %b lives %0d level %0d over %b freeze %b expected 1 3 0 0 0",
        level_restart, lives, level, game_over, freeze);
    end
  endtask

  task automatic test_door();
    bit ok; int sofs;
    player_door_idol = 1; enemies_cleared = 0;
    repeat (10) cyc();
    n_cmp++;
    if (level !== 2'd0 || freeze !== 1'b0) begin
      n_bad++; $display("FAIL door_not_cleared: got level %0d freeze %b expected 0 0", level, freeze);
    end
    enemies_cleared = 1; cyc(); player_door_idol = 0; enemies_cleared = 0;
    n_cmp++;
    if (freeze !== 1'b1 || player_invulnerable !== 1'b1 || level !== 2'd0) begin
      n_bad++; $display("FAIL door_enter: got freeze %b inv %b level %0d expected 1 1 0", freeze, player_invulnerable, level);
    end
    wait_restart(ok, sofs);
    n_cmp++;
    if (!ok || sofs != LEVEL_F || level !== 2'd1 || player_invulnerable !== 1'b0) begin
      n_bad++; $display("FAIL level_done: got ok %0d frames %0d level %0d inv %b expected 1 %0d 1 0",
        ok, sofs, level, player_invulnerable, LEVEL_F);
    end
    for (int lv = 1; lv < MAX_LEVEL; lv++) begin
      player_door_idol = 1; enemies_cleared = 1; cyc(); player_door_idol = 0; enemies_cleared = 0;
      wait_restart(ok, sofs);
      n_cmp++;
      if (!ok || int'(level) != lv + 1) begin
        n_bad++; $display("FAIL level_step: got ok %0d level %0d expected 1 %0d", ok, level, lv + 1);
      end
    end
    player_door_idol = 1; enemies_cleared = 1; cyc(); player_door_idol = 0; enemies_cleared = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (game_won) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok || level !== 2'd3 || freeze !== 1'b1 || game_over !== 1'b0) begin
      n_bad++; $display("FAIL win: got ok %0d level %0d freeze %b over %b expected 1 3 1 0", ok, level, freeze, game_over);
    end
    start_key = 1; cyc(); start_key = 0;
    n_cmp++;
    if (level_restart !== 1'b1 || level !== 2'd0 || game_won !== 1'b0 || lives !== 3'd3) begin
      n_bad++; $display("FAIL win_restart: got restart %b level %0d won %b lives %0d expected 1 0 0 3",
        level_restart, level, game_won, lives);
    end
  endtask

  task automatic test_powerup();
    bit ok; int sofs; int pulses;
    player_hit = 1; cyc(); player_hit = 0;
    wait_restart(ok, sofs);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_inv == 30) begin ok = 1; break; end
      cyc();
    end
    pulses = 0; sofs = 0;
    collision_player_powerUp = 1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (pulses > 0) sofs += int'(sof_at_edge);
      pulses += int'(powerup_taken);
    end
    collision_player_powerUp = 0;
    n_cmp++;
    if (!ok || pulses != 1) begin
      n_bad++; $display("FAIL powerup_single_pulse: got ok %0d pulses %0d expected 1 1", ok, pulses);
    end
    for (int i = 0; i < 3000; i++) begin
      cyc();
      sofs += int'(sof_at_edge);
      if (!player_invulnerable) break;
    end
    n_cmp++;
    if (sofs != POWERUP_F || player_invulnerable !== 1'b0) begin
      n_bad++; $display("FAIL powerup_invuln: got frames %0d inv %b expected %0d 0", sofs, player_invulnerable, POWERUP_F);
    end
    player_hit = 1; player_door_idol = 1; enemies_cleared = 1; cyc();
    player_hit = 0; player_door_idol = 0; enemies_cleared = 0;
    wait_restart(ok, sofs);
    n_cmp++;
    if (!ok || sofs != DEATH_F || lives !== 3'd1 || level !== 2'd0) begin
      n_bad++; $display("FAIL hit_beats_door: got ok %0d frames %0d lives %0d level %0d expected 1 %0d 1 0",
        ok, sofs, lives, level, DEATH_F);
    end
  endtask

  task automatic test_reset_mid_death();
    bit ok; int sofs;
    wait_invuln_clear(ok, sofs);
    player_hit = 1; cyc(); player_hit = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_death == 25 && m_phase == P_DEATH) begin ok = 1; break; end
      cyc();
    end
    reset = 1; cyc(); reset = 0;
    n_cmp++;
    if (!ok || {freeze, player_invulnerable, level_restart, powerup_taken, game_over, game_won} !== 6'b100000
        || lives !== 3'd3 || level !== 2'd0) begin
      n_bad++; $display("FAIL reset_mid_death: got ok %0d flags %b lives %0d level %0d expected 1 100000 3 0", ok,
        {freeze, player_invulnerable, level_restart, powerup_taken, game_over, game_won}, lives, level);
    end
    repeat (3) cyc();
    n_cmp++;
    if (freeze !== 1'b1 || level_restart !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got freeze %b restart %b expected 1 0", freeze, level_restart);
    end
  endtask

  task automatic test_random();
    logic [11:0] exp_v, got_v;
    bit e_inv;
    sof_random = 1;
    reset = 1; cyc(); reset = 0;
    for (int i = 0; i < 5000; i++) begin
      reset                    = ($urandom_range(0, 999) == 0);
      start_key                = ($urandom_range(0, 15) == 0);
      player_hit               = ($urandom_range(0, 29) == 0);
      player_door_idol         = ($urandom_range(0, 39) == 0);
      enemies_cleared          = ($urandom_range(0, 1) == 0);
      collision_player_powerUp = ($urandom_range(0, 5) == 0);
      cyc();
      e_inv = (m_phase == P_PLAY) ? (m_inv != 0) : (m_phase == P_DEATH || m_phase == P_LEVEL);
      exp_v = {m_phase != P_PLAY, e_inv, m_restart, m_pu, m_phase == P_OVER, m_phase == P_WIN,
               m_lives[2:0], m_level[1:0], 1'b0};
      got_v = {freeze, player_invulnerable, level_restart, powerup_taken, game_over, game_won, lives, level, 1'b0};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++; $display("FAIL random_cycle %0d: got %b expected %b", i, got_v, exp_v);
      end
    end
    reset = 0; start_key = 0; player_hit = 0; player_door_idol = 0;
    enemies_cleared = 0; collision_player_powerUp = 0;
    sof_random = 0;
  endtask

  initial begin
    reset = 1; startOfFrame = 0; start_key = 0; player_hit = 0; player_door_idol = 0;
    collision_player_powerUp = 0; enemies_cleared = 0;
    sof_random = 0; frame_cnt = 0; sof_at_edge = 0;
    model_reset();
    test_reset();
    test_start();
    test_hit_death();
    test_game_over();
    test_door();
    test_powerup();
    test_reset_mid_death();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
